// File: rtl/pgen_pkg.sv
// pgen_pkg: shared types and constants for the pattern stream generator
package pgen_pkg;
    typedef enum logic [1:0] {PGEN_SOLID, PGEN_BARS, PGEN_GRAD, PGEN_CHECK} pgen_mode_e;
    typedef enum logic {PGEN_IDLE, PGEN_ACTIVE} pgen_state_e;
    localparam int PIX_W = 32;
    localparam logic [7:0][23:0] BAR_COLOURS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };
endpackage

// File: rtl/pgen_pixel_colour.sv
// pgen_pixel_colour: combinational test-pattern colour for one pixel
module pgen_pixel_colour
    import pgen_pkg::*;
#(
    parameter int X_SIZE     = 640,
    parameter int CHECK_LOG2 = 4,
    parameter int XW         = 10,
    parameter int YW         = 9
) (
    input  pgen_mode_e    mode,
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] y,
    input  logic [23:0]   solid_colour,
    output logic [23:0]   colour
);
    logic [2:0] bar;
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (px >= XW'(k * (X_SIZE / 8))) bar = 3'(k);
    end
    assign colour = mode == PGEN_SOLID ? solid_colour
                  : mode == PGEN_BARS  ? BAR_COLOURS[bar]
                  : mode == PGEN_GRAD  ? {8'(px), 8'(y), 8'h00}
                  : (px[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
endmodule

// File: rtl/pattern_stream_generator.sv
// pattern_stream_generator: AXI4-Stream test-pattern frame source honouring backpressure.
// Define PGEN_SCROLL_EN to scroll modes 1-3 left by SCROLL_STEP pixels per completed frame.
module pattern_stream_generator
    import pgen_pkg::*;
#(
    parameter int X_SIZE          = 640,
    parameter int Y_SIZE          = 480,
    parameter int PIXELS_PER_BEAT = 1,
    parameter int CHECK_LOG2      = 4,
    parameter int SCROLL_STEP     = 1
) (
    input  logic                               out_stream_aclk,
    input  logic                               periph_reset,
    input  logic                               enable,
    input  logic [1:0]                         mode,
    input  logic [23:0]                        solid_colour,
    output logic [PIX_W*PIXELS_PER_BEAT-1:0]   out_stream_tdata,
    output logic [4*PIXELS_PER_BEAT-1:0]       out_stream_tkeep,
    output logic                               out_stream_tvalid,
    input  logic                               out_stream_tready,
    output logic                               out_stream_tlast,
    output logic                               out_stream_tuser,
    output logic [15:0]                        frame_count,
    output logic                               busy
);
    localparam int XW = $clog2(X_SIZE + 1);
    localparam int YW = $clog2(Y_SIZE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - PIXELS_PER_BEAT);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    pgen_state_e state, state_nx;
    pgen_mode_e mode_q, mode_sel;
    logic [23:0] colour_q, colour_sel;
    logic [XW-1:0] x, nx;
    logic [YW-1:0] y, ny;
    logic [PIX_W*PIXELS_PER_BEAT-1:0] tdata_nx;
    logic hs, eol, last_beat, done, start, adv;

    // tvalid is exactly the ACTIVE state, so a handshake needs only tready
    assign busy = state == PGEN_ACTIVE;
    assign out_stream_tvalid = busy;
    assign out_stream_tkeep = '1;
    assign hs = busy && out_stream_tready;
    assign eol = x == X_LAST;
    assign last_beat = eol && y == Y_LAST;
    assign done = hs && last_beat;

    always_ff @(posedge out_stream_aclk or posedge periph_reset)
        if (periph_reset) state <= PGEN_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == PGEN_IDLE && enable) state_nx = PGEN_ACTIVE;
        if (done && !enable) state_nx = PGEN_IDLE;
    end

    always_comb begin
        start = enable && (state == PGEN_IDLE || done);
        adv = hs && !last_beat;
        nx = (start || eol) ? '0 : x + XW'(PIXELS_PER_BEAT);
        ny = start ? '0 : eol ? y + YW'(1) : y;
    end

    assign mode_sel = pgen_mode_e'(start ? mode : mode_q);
    assign colour_sel = start ? solid_colour : colour_q;

`ifdef PGEN_SCROLL_EN
    localparam logic [XW:0] X_FULL = (XW+1)'(X_SIZE);
    logic [XW-1:0] acc, acc_nx;
    logic [XW:0] acc_sum;
    // acc tracks frame_count*SCROLL_STEP mod X_SIZE without a multiplier or divider
    assign acc_sum = {1'b0, acc} + (XW+1)'(SCROLL_STEP);
    assign acc_nx = !done ? acc : frame_count == 16'hFFFF ? '0
                  : acc_sum >= X_FULL ? XW'(acc_sum - X_FULL) : XW'(acc_sum);
    always_ff @(posedge out_stream_aclk or posedge periph_reset)
        if (periph_reset) acc <= '0;
        else acc <= acc_nx;
`endif

    for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_pix
        logic [XW-1:0] px;
        logic [23:0] colour;
`ifdef PGEN_SCROLL_EN
        logic [XW:0] sum;
        assign sum = {1'b0, nx} + (XW+1)'(i) + {1'b0, acc_nx};
        assign px = sum >= X_FULL ? XW'(sum - X_FULL) : XW'(sum);
`else
        assign px = nx + XW'(i);
`endif
        pgen_pixel_colour #(
            .X_SIZE(X_SIZE), .CHECK_LOG2(CHECK_LOG2), .XW(XW), .YW(YW)
        ) u_colour (
            .mode(mode_sel), .px(px), .y(ny), .solid_colour(colour_sel), .colour(colour)
        );
        assign tdata_nx[PIX_W*i +: PIX_W] = {8'h00, colour};
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset)
        if (periph_reset) begin
            x <= '0;
            y <= '0;
            mode_q <= PGEN_SOLID;
            colour_q <= '0;
            out_stream_tdata <= '0;
            out_stream_tlast <= 1'b0;
            out_stream_tuser <= 1'b0;
            frame_count <= '0;
        end else begin
            if (start || adv) begin
                x <= nx;
                y <= ny;
                out_stream_tdata <= tdata_nx;
                out_stream_tlast <= nx == X_LAST;
                out_stream_tuser <= start;
            end
            if (start) begin
                mode_q <= mode_sel;
                colour_q <= colour_sel;
            end
            if (done) frame_count <= frame_count + 16'd1;
        end
endmodule

// File: tb/tb_pattern_stream_generator.sv
// tb_pattern_stream_generator: scoreboard bench for pattern_stream_generator (16x4, 2 px/beat)
module tb_pattern_stream_generator;
    localparam int XS = 16, YS = 4, PPB = 2, CL = 2, BEATS = XS / PPB * YS;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    typedef struct packed { logic [63:0] d; logic l; logic u; } beat_t;

    logic clk = 0, rst = 1, enable = 0, tready = 1;
    logic [1:0] mode = 0;
    logic [23:0] colour = 0;
    logic [63:0] tdata;
    logic [7:0] tkeep;
    logic tvalid, tlast, tuser, busy;
    logic [15:0] fc;
    beat_t exp_q[$];
    beat_t prev, cur, e;
    bit stall = 0, bp = 0;
    int total = 0, bad = 0, accepted = 0;

    always #5 clk = ~clk;

    pattern_stream_generator #(
        .X_SIZE(XS), .Y_SIZE(YS), .PIXELS_PER_BEAT(PPB), .CHECK_LOG2(CL), .SCROLL_STEP(1)
    ) dut (
        .out_stream_aclk(clk), .periph_reset(rst), .enable(enable), .mode(mode),
        .solid_colour(colour), .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
        .out_stream_tvalid(tvalid), .out_stream_tready(tready), .out_stream_tlast(tlast),
        .out_stream_tuser(tuser), .frame_count(fc), .busy(busy)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [23:0] pix(input int m, input logic [23:0] c, input int px, input int py);
        if (m == 0) return c;
        if (m == 1) return BARS[px / (XS / 8)];
        if (m == 2) return {px[7:0], py[7:0], 8'h00};
        return (((px >> CL) ^ (py >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic push_frame(input int m, input logic [23:0] c);
        for (int py = 0; py < YS; py++)
            for (int bx = 0; bx < XS; bx += PPB)
                exp_q.push_back(beat_t'{d: {8'h00, pix(m, c, bx + 1, py), 8'h00, pix(m, c, bx, py)},
                                        l: bx == XS - PPB, u: bx == 0 && py == 0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        int t = 0;
        while (accepted < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (accepted < n) begin
            total++;
            bad++;
            $display("FAIL timeout: accepted %0d want %0d", accepted, n);
        end
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        cur = '{d: tdata, l: tlast, u: tuser};
        if (stall && tvalid) check("stall_hold", cur, prev);
        if (tvalid && tready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got %h want none", cur);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d", accepted), cur, e);
            end
        end
        stall = tvalid && !tready;
        prev = cur;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: accepted %0d", accepted);
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) tick();
        check("reset_state", {tvalid, busy, tlast, tuser, fc, tdata}, '0);
        check("tkeep", tkeep, 8'hFF);
        rst = 0;
        tick();
        // solid colour, two back-to-back frames
        push_frame(0, 24'h123456);
        push_frame(0, 24'h123456);
        mode = 0; colour = 24'h123456; enable = 1; base = accepted;
        check("idle_tvalid", tvalid, 0);
        tick();
        check("first_beat", {tvalid, busy, tuser}, 3'b111);
        wait_acc(base + BEATS);
        check("frame_boundary", {tvalid, tuser, fc}, {2'b11, 16'd1});
        enable = 0;
        wait_acc(base + 2 * BEATS);
        check("stop_after_frame", {tvalid, busy, fc}, {2'b00, 16'd2});
        // random backpressure
        push_frame(0, 24'h123456);
        bp = 1; enable = 1; base = accepted;
        tick();
        enable = 0;
        wait_acc(base + BEATS);
        bp = 0;
        check("bp_stop", {tvalid, busy, fc}, {2'b00, 16'd3});
        // colour bars
        push_frame(1, 24'h0);
        mode = 1; enable = 1; base = accepted;
        tick();
        enable = 0;
        wait_acc(base + BEATS);
        check("bars_stop", {tvalid, fc}, {1'b0, 16'd4});
        // mode and colour change mid-frame take effect at the next frame
        push_frame(0, 24'hABCDEF);
        push_frame(3, 24'hABCDEF);
        mode = 0; colour = 24'hABCDEF; enable = 1; base = accepted;
        wait_acc(base + 10);
        mode = 3; colour = 24'h111111;
        wait_acc(base + BEATS);
        enable = 0;
        wait_acc(base + 2 * BEATS);
        check("switch_stop", {tvalid, fc}, {1'b0, 16'd6});
        // enable dropped mid-frame: gradient frame still completes
        push_frame(2, 24'h0);
        mode = 2; enable = 1; base = accepted;
        wait_acc(base + 5);
        enable = 0;
        wait_acc(base + BEATS);
        check("drop_enable_stop", {tvalid, busy, fc}, {2'b00, 16'd7});
        repeat (3) tick();
        check("stays_idle", {tvalid, busy}, 2'b00);
        // reset mid-frame aborts, then a clean restart
        push_frame(0, 24'h123456);
        mode = 0; colour = 24'h123456; enable = 1; base = accepted;
        wait_acc(base + 12);
        rst = 1; enable = 0;
        #1;
        check("reset_abort", {tvalid, busy, fc}, '0);
        exp_q.delete();
        tick();
        rst = 0;
        tick();
        push_frame(0, 24'h654321);
        colour = 24'h654321; enable = 1;
        tick();
        check("restart", {tvalid, tuser, fc}, {2'b11, 16'd0});
        enable = 0; base = accepted;
        wait_acc(base + BEATS);
        check("restart_stop", {tvalid, fc}, {1'b0, 16'd1});
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
